// File: rtl/gray_seq_counter.sv
// gray_seq_counter: sequenced up/down counter with valid/ready output.
// Define GRAY_OUT_EN to add a registered Gray-coded copy on gray_out.
module gray_seq_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef GRAY_OUT_EN
  output logic [WIDTH-1:0] gray_out,
`endif
  output logic             done
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic             up_q;
  logic             hs;
  logic             at_term;
  logic             go;
  logic             quit;
  logic             adv_step;
  logic             adv_term;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] bin_nxt;

  assign hs      = out_valid & out_ready;
  assign at_term = up_q ? (bin_out == LIM)
                        : (bin_out == '0);
  assign first   = (load_val > LIM) ? LIM
                                    : load_val;

  assign go       = (state == IDLE) & start & ~stop;
  assign quit     = (state == RUN) & stop;
  assign adv_step = (state == RUN) & ~stop
                  & hs & ~at_term;
  assign adv_term = (state == RUN) & ~stop
                  & hs & at_term;

  // A stop wins over a same-cycle handshake: value is frozen.
  always_comb begin
    bin_nxt = bin_out;
    unique case (1'b1)
      go:
        bin_nxt = first;
      adv_step:
        bin_nxt = up_q ? bin_out + ONE
                       : bin_out - ONE;
      adv_term && (WRAP != 0):
        bin_nxt = up_q ? '0 : LIM;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      up_q      <= 1'b1;
      bin_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bin_out <= bin_nxt;
      done    <= 1'b0;
      unique case (1'b1)
        go: begin
          state     <= RUN;
          up_q      <= dir;
          out_valid <= 1'b1;
          busy      <= 1'b1;
        end
        quit: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        adv_term && (WRAP == 0): begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_out <= '0;
    end else begin
      gray_out <= bin_nxt ^ (bin_nxt >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_gray_seq_counter.sv
// Bench for gray_seq_counter: vector table, directed corners and
// randomized traffic against a behavioural model (two configs).
module tb_gray_seq_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, dir, rdy;
  logic [3:0] lv;
  logic [3:0] b0, b1, g0, g1;
  logic       v0, v1, bs0, bs1, d0, d1;
  bit         mon_en = 1'b0;
  int         ncmp = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  gray_seq_counter #(.WIDTH(4), .LIMIT(15), .WRAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .dir(dir), .load_val(lv), .bin_out(b0), .out_valid(v0),
    .out_ready(rdy), .busy(bs0),
`ifdef GRAY_OUT_EN
    .gray_out(g0),
`endif
    .done(d0)
  );

  gray_seq_counter #(.WIDTH(4), .LIMIT(9), .WRAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .dir(dir), .load_val(lv), .bin_out(b1), .out_valid(v1),
    .out_ready(rdy), .busy(bs1),
`ifdef GRAY_OUT_EN
    .gray_out(g1),
`endif
    .done(d1)
  );

`ifndef GRAY_OUT_EN
  assign g0 = 4'h0;
  assign g1 = 4'h0;
`endif

  // Behavioural model: sequence position as a plain integer.
  typedef struct {
    bit run;
    bit valid;
    bit done;
    bit up;
    int val;
  } mst_t;

  mst_t m0, m1;

  function automatic mst_t mreset();
    mst_t s;
    s.run = 0; s.valid = 0; s.done = 0; s.up = 1; s.val = 0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, int lim, bit wrap,
                                 bit st, bit sp, bit d,
                                 int lvi, bit r);
    mst_t n;
    bit   term;
    n = s;
    n.done = 0;
    if (!s.run) begin
      if (st && !sp) begin
        n.run = 1; n.valid = 1; n.up = d;
        n.val = (lvi > lim) ? lim : lvi;
      end
    end else if (sp) begin
      n.run = 0; n.valid = 0;
    end else if (r) begin
      term = s.up ? (s.val == lim) : (s.val == 0);
      if (term && !wrap) begin
        n.run = 0; n.valid = 0; n.done = 1;
      end else if (s.up) begin
        n.val = (s.val + 1) % (lim + 1);
      end else begin
        n.val = (s.val + lim) % (lim + 1);
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] mpack(mst_t s);
    logic [3:0] v;
    v = s.val[3:0];
    return {1'b0, v, s.valid, s.run, s.done};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset();
      m1 <= mreset();
    end else begin
      m0 <= mstep(m0, 15, 0, start, stop, dir, int'(lv), rdy);
      m1 <= mstep(m1, 9, 1, start, stop, dir, int'(lv), rdy);
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] gref(int v);
    logic [3:0] x;
    x = v[3:0];
    return x ^ (x >> 1);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_u0", {1'b0, b0, v0, bs0, d0}, mpack(m0));
      chk("model_u1", {1'b0, b1, v1, bs1, d1}, mpack(m1));
`ifdef GRAY_OUT_EN
      chk("gray_u0", {4'h0, g0}, {4'h0, gref(m0.val)});
      chk("gray_u1", {4'h0, g1}, {4'h0, gref(m1.val)});
`endif
    end
  end

  typedef struct {
    logic       st, sp, d;
    logic [3:0] l;
    logic       r;
    logic [3:0] eb;
    logic       ev, ebz, ed;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic st, sp, d, input logic [3:0] l,
                      input logic r, input logic [3:0] eb,
                      input logic ev, ebz, ed);
    vec_t x;
    x.st = st; x.sp = sp; x.d = d; x.l = l; x.r = r;
    x.eb = eb; x.ev = ev; x.ebz = ebz; x.ed = ed;
    vq.push_back(x);
  endtask

  task automatic drive(input logic st, sp, d,
                       input logic [3:0] l, input logic r);
    start = st; stop = sp; dir = d; lv = l; rdy = r;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [3:0] gt[16];

  initial begin
    drive(0, 0, 1, 4'd0, 1);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();
    #1 rst_n = 1'b1;
    chk("reset_u0", {1'b0, b0, v0, bs0, d0}, 8'h00);
    chk("reset_u1", {1'b0, b1, v1, bs1, d1}, 8'h00);

    // Full up count, backpressure, collisions (u0: LIMIT 15, stop mode).
    addv(1, 0, 1, 13, 1, 13, 1, 1, 0);
    addv(0, 0, 1, 0, 1, 14, 1, 1, 0);
    addv(0, 0, 1, 0, 1, 15, 1, 1, 0);
    addv(0, 0, 1, 0, 1, 15, 0, 0, 1);
    addv(0, 0, 1, 0, 1, 15, 0, 0, 0);
    addv(1, 0, 0, 5, 0, 5, 1, 1, 0);
    for (int i = 0; i < 4; i++) addv(0, 0, 0, 0, 0, 5, 1, 1, 0);
    for (int i = 4; i >= 0; i--)
      addv(0, 0, 0, 0, 1, 4'(i), 1, 1, 0);
    addv(0, 0, 0, 0, 1, 0, 0, 0, 1);
    addv(0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(1, 1, 0, 7, 1, 0, 0, 0, 0);
    addv(1, 0, 1, 2, 1, 2, 1, 1, 0);
    addv(1, 0, 0, 9, 1, 3, 1, 1, 0);
    addv(0, 1, 0, 0, 1, 3, 0, 0, 0);
    addv(0, 0, 0, 0, 1, 3, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].sp, vq[i].d, vq[i].l, vq[i].r);
      tick();
      chk($sformatf("vec%0d", i), {1'b0, b0, v0, bs0, d0},
          {1'b0, vq[i].eb, vq[i].ev, vq[i].ebz, vq[i].ed});
      #1;
    end

    // Async reset mid-run after two transfers.
    drive(1, 0, 1, 4'd3, 1);
    tick(); #1 drive(0, 0, 1, 4'd0, 1);
    tick(); #1;
    tick();
    chk("run_before_rst", {4'h0, b0}, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_u0", {1'b0, b0, v0, bs0, d0}, 8'h00);
    chk("async_rst_u1", {1'b0, b1, v1, bs1, d1}, 8'h00);
    tick(); #1 rst_n = 1'b1;

    // Wrap on u1 (LIMIT 9): 8,9,0,1 then stop without done.
    drive(1, 0, 1, 4'd8, 1);
    tick(); chk("wrap_8", {1'b0, b1, v1, bs1, d1}, {1'b0, 4'd8, 3'b110});
    #1 drive(0, 0, 1, 4'd0, 1);
    tick(); chk("wrap_9", {4'h0, b1}, 8'd9);
    #1;
    tick(); chk("wrap_0", {1'b0, b1, v1, bs1, d1}, {1'b0, 4'd0, 3'b110});
    #1;
    tick(); chk("wrap_1", {4'h0, b1}, 8'd1);
    #1 drive(0, 1, 1, 4'd0, 1);
    tick(); chk("wrap_stop", {1'b0, b1, v1, bs1, d1}, {1'b0, 4'd1, 3'b000});
    #1 drive(1, 1, 1, 4'd4, 1);
    tick(); chk("ss_idle", {1'b0, b1, v1, bs1, d1}, {1'b0, 4'd1, 3'b000});

    // Clamp on u1, then start while running is ignored.
    #1 drive(1, 0, 0, 4'd12, 0);
    tick(); chk("clamp", {1'b0, b1, v1, bs1, d1}, {1'b0, 4'd9, 3'b110});
    #1 drive(1, 0, 1, 4'd3, 1);
    tick(); chk("start_in_run", {4'h0, b1}, 8'd8);
    #1 drive(0, 0, 1, 4'd0, 1);
    tick(); chk("run_cont", {4'h0, b1}, 8'd7);
    #1 drive(0, 1, 0, 4'd0, 0);
    tick(); #1;

    // Restart accepted in the cycle after done (u0).
    drive(1, 0, 1, 4'd14, 1);
    tick(); #1 drive(0, 0, 1, 4'd0, 1);
    tick(); chk("pre_done", {4'h0, b0}, 8'd15);
    #1;
    tick(); chk("done", {1'b0, b0, v0, bs0, d0}, {1'b0, 4'd15, 3'b001});
    #1 drive(1, 0, 1, 4'd1, 1);
    tick(); chk("restart", {1'b0, b0, v0, bs0, d0}, {1'b0, 4'd1, 3'b110});
    #1 drive(0, 1, 0, 4'd0, 0);
    tick(); #1;

`ifdef GRAY_OUT_EN
    gt = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    drive(1, 0, 1, 4'd0, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("gray%0d", i), {g0, b0}, {gt[i], 4'(i)});
      #1 drive(0, 0, 1, 4'd0, 1);
    end
    tick(); #1 drive(0, 1, 0, 4'd0, 0);
    tick(); #1;
`endif

    // Randomized traffic; the negedge monitor checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick(); #1 rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0);
      tick(); #1;
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
